// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes and controller state encoding for the data-memory path
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the byte/half lane of a word and sign- or zero-extends it
module dmem_load_align (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    import dmem_pkg::*;

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = word[8*offset +: 8];
        h    = offset[1] ? word[31:16] : word[15:0];
        data = (funct3 == F3_B)  ? {{24{b[7]}}, b} :
               (funct3 == F3_BU) ? {24'h0, b} :
               (funct3 == F3_H)  ? {{16{h[15]}}, h} :
               (funct3 == F3_HU) ? {16'h0, h} : word;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data memory with single-cycle stores and fixed-latency,
// stall-guarded loads
module dmem_ctrl #(
    parameter int DEPTH    = 32,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_stall,
    output logic        o_fault
);
    import dmem_pkg::*;

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] CNT_INIT = (READ_LAT > 1) ? 3'(READ_LAT - 2) : 3'd0;

    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic [31:0] mem [DEPTH];
    logic [31:0] word_q, ld_val, wd;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        lf_q, sf_q;
    logic [AW-1:0] widx;
    logic [3:0]  be;
    logic        accept, fault, wr;

    assign widx   = i_addr[AW+1:2];
    assign accept = reset && i_req && (state == IDLE || state == DONE);
    assign fault  = ({2'b00, i_addr[31:2]} >= 32'(DEPTH))
                 || (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11)
                 || (i_we && i_funct3[2])
                 || (i_funct3[1:0] == 2'b01 && i_addr[0])
                 || (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
    assign wr     = accept && i_we && !fault;
    assign be     = (i_funct3 == F3_B) ? 4'b0001 << i_addr[1:0] :
                    (i_funct3 == F3_H) ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd     = (i_funct3 == F3_B) ? {4{i_wdata[7:0]}} :
                    (i_funct3 == F3_H) ? {2{i_wdata[15:0]}} : i_wdata;

    // Storage and load capture carry no reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (wr)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
        if (accept && !i_we) begin
            word_q <= mem[widx];
            off_q  <= i_addr[1:0];
            f3_q   <= i_funct3;
            lf_q   <= fault;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
            sf_q  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (accept && !i_we) ? CNT_INIT :
                     (state == WAIT && cnt != 3'd0) ? cnt - 3'd1 : cnt;
            sf_q  <= accept && i_we && fault;
        end
    end

    always_comb begin
        state_nx = state;
        if (accept && !i_we)
            state_nx = (READ_LAT == 1) ? DONE : WAIT;
        else if (state == WAIT)
            state_nx = (cnt == 3'd0) ? DONE : WAIT;
        else if (state == DONE)
            state_nx = IDLE;
    end

    dmem_load_align u_align (
        .word   (word_q),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (ld_val)
    );

    always_comb begin
        o_rvalid = (state == DONE);
        o_rdata  = (state == DONE && !lf_q) ? ld_val : 32'h0;
        o_fault  = (state == DONE && lf_q) || sf_q;
        o_stall  = (accept && !i_we) || (state == WAIT);
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of two controller instances (read latency 1 and 4)
// driven from the same request stream
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [31:0] rd1, rd4;
    logic        rv1, st1, ft1, rv4, st4, ft4;
    int          vec = 0;
    int          miss = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(32), .READ_LAT(1)) u_l1 (
        .clk(clk), .reset(reset), .i_req(req), .i_we(we), .i_funct3(f3),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rd1), .o_rvalid(rv1),
        .o_stall(st1), .o_fault(ft1)
    );

    dmem_ctrl #(.DEPTH(32), .READ_LAT(4)) u_l4 (
        .clk(clk), .reset(reset), .i_req(req), .i_we(we), .i_funct3(f3),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rd4), .o_rvalid(rv4),
        .o_stall(st4), .o_fault(ft4)
    );

    task automatic store(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; f3 = fn; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issues one load pulse and samples both instances at their expected DONE cycles
    task automatic load(input logic [2:0] fn, input logic [31:0] a,
                        output logic s0, output logic s1,
                        output logic [31:0] r1, output logic v1, output logic f1,
                        output logic [31:0] r4, output logic v4, output logic f4);
        req = 1'b1; we = 1'b0; f3 = fn; addr = a;
        @(negedge clk); s0 = st1;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk); s1 = st1; r1 = rd1; v1 = rv1; f1 = ft1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk); r4 = rd4; v4 = rv4; f4 = ft4;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; req = 1'b1; we = 1'b0; f3 = F3_W; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        vec++; if (st1 !== 1'b0 || st4 !== 1'b0) begin miss++; $display("FAIL reset_stall got %b/%b exp 0/0", st1, st4); end
        vec++; if (rv1 !== 1'b0 || rv4 !== 1'b0 || ft1 !== 1'b0 || ft4 !== 1'b0) begin miss++; $display("FAIL reset_valid_fault got %b%b%b%b exp 0000", rv1, rv4, ft1, ft4); end
        vec++; if (rd1 !== 32'h0 || rd4 !== 32'h0) begin miss++; $display("FAIL reset_rdata got %h/%h exp 0", rd1, rd4); end
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        vec++; if ({st1, rv1, ft1, st4, rv4, ft4} !== 6'b0 || rd1 !== 32'h0) begin miss++; $display("FAIL idle_outputs got %b rd %h exp 0", {st1, rv1, ft1, st4, rv4, ft4}, rd1); end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load_word;
        logic s0, s1, v1, f1, v4, f4;
        logic [31:0] r1, r4;
        req = 1'b1; we = 1'b1; f3 = F3_W; addr = 32'h8; wdata = 32'hDEADBEEF;
        @(negedge clk);
        vec++; if (st1 !== 1'b0 || st4 !== 1'b0) begin miss++; $display("FAIL store_stall got %b/%b exp 0/0", st1, st4); end
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        load(F3_W, 32'h8, s0, s1, r1, v1, f1, r4, v4, f4);
        vec++; if (s0 !== 1'b1 || s1 !== 1'b0) begin miss++; $display("FAIL lw_stall got %b%b exp 10", s0, s1); end
        vec++; if (v1 !== 1'b1 || r1 !== 32'hDEADBEEF || f1 !== 1'b0) begin miss++; $display("FAIL lw_l1 got v%b %h f%b exp v1 deadbeef f0", v1, r1, f1); end
        vec++; if (v4 !== 1'b1 || r4 !== 32'hDEADBEEF) begin miss++; $display("FAIL lw_l4 got v%b %h exp v1 deadbeef", v4, r4); end
    endtask

    task automatic test_sign_ext;
        logic s0, s1, v1, f1, v4, f4;
        logic [31:0] r1, r4;
        logic [2:0]  fns [5]  = '{F3_B, F3_BU, F3_H, F3_HU, F3_B};
        logic [31:0] ads [5]  = '{32'h0, 32'h1, 32'h2, 32'h0, 32'h3};
        logic [31:0] exps [5] = '{32'h0, 32'hFF, 32'hFFFFFFFF, 32'h0000FF00, 32'hFFFFFFFF};
        store(F3_W, 32'h0, 32'hFFFFFF00);
        for (int i = 0; i < 5; i++) begin
            load(fns[i], ads[i], s0, s1, r1, v1, f1, r4, v4, f4);
            vec++; if (r1 !== exps[i] || v1 !== 1'b1) begin miss++; $display("FAIL ext_%0d got %h v%b exp %h", i, r1, v1, exps[i]); end
        end
    endtask

    task automatic test_partial;
        logic s0, s1, v1, f1, v4, f4;
        logic [31:0] r1, r4;
        store(F3_W, 32'h4, 32'h11223344);
        store(F3_B, 32'h5, 32'h000000AA);
        store(F3_H, 32'h6, 32'h0000BEEF);
        load(F3_W, 32'h4, s0, s1, r1, v1, f1, r4, v4, f4);
        vec++; if (r1 !== 32'hBEEFAA44) begin miss++; $display("FAIL partial got %h exp beefaa44", r1); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_rd;
        for (int c = 0; c < 9; c++) begin
            req = (c == 0 || c == 4); we = 1'b0; f3 = F3_W; addr = (c == 4) ? 32'h4 : 32'h8;
            exp_rd = (c == 4) ? 32'hDEADBEEF : (c == 8) ? 32'hBEEFAA44 : 32'h0;
            @(negedge clk);
            vec++; if (st4 !== (c < 8)) begin miss++; $display("FAIL lat_stall_c%0d got %b exp %b", c, st4, c < 8); end
            vec++; if (rv4 !== (c == 4 || c == 8) || rd4 !== exp_rd) begin miss++; $display("FAIL lat_data_c%0d got v%b %h exp %h", c, rv4, rd4, exp_rd); end
            @(posedge clk); #1;
        end
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_faults;
        logic s0, s1, v1, f1, v4, f4;
        logic [31:0] r1, r4;
        load(F3_W, 32'h6, s0, s1, r1, v1, f1, r4, v4, f4);
        vec++; if (v1 !== 1'b1 || r1 !== 32'h0 || f1 !== 1'b1) begin miss++; $display("FAIL misaligned_lw got v%b %h f%b exp v1 0 f1", v1, r1, f1); end
        vec++; if (v4 !== 1'b1 || r4 !== 32'h0 || f4 !== 1'b1) begin miss++; $display("FAIL misaligned_lw_l4 got v%b %h f%b exp v1 0 f1", v4, r4, f4); end
        for (int k = 0; k < 2; k++) begin
            req = 1'b1; we = 1'b1;
            f3 = (k == 0) ? F3_H : F3_BU; addr = (k == 0) ? 32'h3 : 32'h8; wdata = 32'h12345655;
            @(negedge clk);
            vec++; if (ft1 !== 1'b0 || st1 !== 1'b0) begin miss++; $display("FAIL st_fault_early_%0d got f%b s%b exp 0 0", k, ft1, st1); end
            @(posedge clk); #1;
            req = 1'b0; we = 1'b0;
            @(negedge clk);
            vec++; if (ft1 !== 1'b1 || ft4 !== 1'b1) begin miss++; $display("FAIL st_fault_pulse_%0d got %b/%b exp 1/1", k, ft1, ft4); end
            @(posedge clk); #1;
            @(negedge clk);
            vec++; if (ft1 !== 1'b0) begin miss++; $display("FAIL st_fault_end_%0d got %b exp 0", k, ft1); end
            @(posedge clk); #1;
        end
        load(F3_W, 32'h0, s0, s1, r1, v1, f1, r4, v4, f4);
        vec++; if (r1 !== 32'hFFFFFF00 || f1 !== 1'b0) begin miss++; $display("FAIL sh_fault_nowrite got %h f%b exp ffffff00 f0", r1, f1); end
        load(F3_W, 32'h8, s0, s1, r1, v1, f1, r4, v4, f4);
        vec++; if (r1 !== 32'hDEADBEEF) begin miss++; $display("FAIL sbu_fault_nowrite got %h exp deadbeef", r1); end
        load(F3_W, 32'h80, s0, s1, r1, v1, f1, r4, v4, f4);
        vec++; if (v1 !== 1'b1 || r1 !== 32'h0 || f1 !== 1'b1) begin miss++; $display("FAIL range_lw got v%b %h f%b exp v1 0 f1", v1, r1, f1); end
        load(3'b011, 32'h0, s0, s1, r1, v1, f1, r4, v4, f4);
        vec++; if (f1 !== 1'b1 || r1 !== 32'h0) begin miss++; $display("FAIL illegal_f3 got f%b %h exp f1 0", f1, r1); end
        load(F3_H, 32'h2, s0, s1, r1, v1, f1, r4, v4, f4);
        vec++; if (f1 !== 1'b0 || r1 !== 32'hFFFFFFFF) begin miss++; $display("FAIL aligned_lh got f%b %h exp f0 ffffffff", f1, r1); end
    endtask

    task automatic test_reset_midload;
        logic s0, s1, v1, f1, v4, f4;
        logic [31:0] r1, r4;
        int seen = 0;
        req = 1'b1; we = 1'b0; f3 = F3_W; addr = 32'h4;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        vec++; if (st4 !== 1'b1) begin miss++; $display("FAIL midload_pre_stall got %b exp 1", st4); end
        reset = 1'b0;
        #1;
        vec++; if (st4 !== 1'b0 || rv4 !== 1'b0 || ft4 !== 1'b0 || rd4 !== 32'h0) begin miss++; $display("FAIL midload_reset got s%b v%b f%b %h exp 0", st4, rv4, ft4, rd4); end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (rv4 !== 1'b0 || st4 !== 1'b0) seen++;
        end
        vec++; if (seen !== 0) begin miss++; $display("FAIL midload_dropped got %0d active cycles exp 0", seen); end
        @(posedge clk); #1;
        load(F3_W, 32'h4, s0, s1, r1, v1, f1, r4, v4, f4);
        vec++; if (r1 !== 32'hBEEFAA44 || r4 !== 32'hBEEFAA44 || v4 !== 1'b1) begin miss++; $display("FAIL midload_data got %h/%h v%b exp beefaa44", r1, r4, v4); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_load_word();
        test_sign_ext();
        test_partial();
        test_back_to_back();
        test_faults();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
